instr_sequencer: RTL

Multi-cycle instruction sequencer for the KGP_miniRISC core. It steps the datapath through fetch, decode, execute, memory and writeback, and runs the instruction/data memory request-acknowledge handshakes. It gates the register-file and PC write strobes using the combinational decode outputs of `control` (reg_write, mem_read, mem_write, plus a decoded halt). It sits between `control` and the datapath registers (PC, IR, register file) and the two memory ports.

---
 rtl/miniRISC_pkg.sv | 17 +
 rtl/instr_sequencer_wait_timer.sv | 27 ++
 rtl/instr_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/miniRISC_pkg.sv
// Shared definitions for the KGP_miniRISC sequencer:
// state encoding and the default ack timeout.
package miniRISC_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/instr_sequencer_wait_timer.sv
// Ack wait counter shared by FETCH and MEM;
// expired flags count == TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory handshakes, ack timeout and retire counter.
module instr_sequencer
  import miniRISC_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             reg_write_d,
  input  logic             mem_read_d,
  input  logic             mem_write_d,
  input  logic             halt_d,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write_en,
  output logic             busy,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t state_q;
  state_t state_n;
  logic   tmr_clr;
  logic   tmr_en;
  logic   expired;
  logic   to_err;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_comb begin
    state_n      = state_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write_en = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    tmr_clr      = 1'b1;
    tmr_en       = 1'b0;
    to_err       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_n = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        tmr_clr  = 1'b0;
        // an ack in the expiry cycle still wins
        if (imem_ack) begin
          ir_write = 1'b1;
          state_n  = S_DECODE;
        end else if (expired) begin
          to_err  = 1'b1;
          state_n = S_HALT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_DECODE: begin
        busy    = 1'b1;
        state_n = halt_d ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_n = (mem_read_d | mem_write_d) ? S_MEM : S_WB;
      end
      S_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = mem_write_d;
        tmr_clr  = 1'b0;
        if (dmem_ack) begin
          state_n = S_WB;
        end else if (expired) begin
          to_err  = 1'b1;
          state_n = S_HALT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_WB: begin
        busy         = 1'b1;
        pc_write     = 1'b1;
        reg_write_en = reg_write_d;
        state_n      = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bus_err <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_n;
      if (to_err) bus_err <= 1'b1;
      if (state_q == S_WB) retired <= retired + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule
